// File: rtl/pc_fetch_unit.sv
// Program counter and next-address stage for the single-cycle MIPS datapath.
// Word-addressed fetch with jr/jump/branch redirects; halts once the next PC leaves instruction memory.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr_sel,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] next_pc;
  logic [31:0] pc_next;
  logic [31:0] count_next;
  logic [31:0] branch_ext;

  assign pc_plus1    = pc + 32'd1;
  assign branch_ext  = {{16{branch_offset[15]}}, branch_offset};
  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

  // Redirect priority: jr beats jump beats branch; losers are dropped.
  always_comb begin
    next_pc = pc_plus1;
    if (jr_sel) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = {pc_plus1[31:26], jump_target};
    end else if (branch_taken) begin
      next_pc = pc_plus1 + branch_ext;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = instr_count;
    case (state)
      IDLE: state_next = RUN;
      RUN: begin
        if (!stall) begin
          // The instruction at pc retires even when its successor is out of range.
          count_next = instr_count + 32'd1;
          if (next_pc < MEM_LIMIT) begin
            pc_next = next_pc;
          end else begin
            state_next = HALT;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_count <= 32'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle reference model comparison
// plus directed scenarios with hand-computed expectations.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam int unsigned MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr_sel;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] instr_count;

  int checks = 0;
  int passes = 0;

  pc_fetch_unit #(
    .RESET_PC (RESET_PC),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr_sel       (jr_sel),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .fetch_valid  (fetch_valid),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Reference model: a machine that, once one warm-up cycle after reset has
  // elapsed, retires one instruction per unstalled cycle until its successor
  // address falls outside memory.
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          m_started;
  bit          m_stopped;
  bit          model_ready = 1'b0;

  function automatic logic [31:0] model_target(input logic [31:0] cur);
    logic [31:0] seq;
    logic [31:0] off;
    seq = cur + 32'd1;
    off = 32'($signed(branch_offset));
    if (jr_sel)            return jr_target;
    else if (jump)         return (seq & 32'hFC00_0000) | {6'd0, jump_target};
    else if (branch_taken) return seq + off;
    else                   return seq;
  endfunction

  always @(posedge clk) begin
    logic [31:0] target;
    if (reset) begin
      m_pc        = RESET_PC;
      m_count     = 32'd0;
      m_started   = 1'b0;
      m_stopped   = 1'b0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      if (!m_started) begin
        m_started = 1'b1;
      end else if (!m_stopped && !stall) begin
        target  = model_target(m_pc);
        m_count = m_count + 32'd1;
        if (target < 32'(MEM_WORDS)) m_pc = target;
        else                         m_stopped = 1'b1;
      end
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    if (model_ready) begin
      compare("model_pc",          pc,          m_pc);
      compare("model_pc_plus1",    pc_plus1,    m_pc + 32'd1);
      compare("model_instr_count", instr_count, m_count);
      compare("model_fetch_valid", {31'd0, fetch_valid}, {31'd0, m_started && !m_stopped});
      compare("model_halted",      {31'd0, halted},      {31'd0, m_stopped});
    end
  end

  task automatic applyStimulus(input logic rst, input logic stl,
                               input logic br, input logic [15:0] off,
                               input logic jmp, input logic [25:0] jt,
                               input logic jr, input logic [31:0] jrt);
    reset         = rst;
    stall         = stl;
    branch_taken  = br;
    branch_offset = off;
    jump          = jmp;
    jump_target   = jt;
    jr_sel        = jr;
    jr_target     = jrt;
    @(posedge clk);
    #1;
  endtask

  task automatic stepIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_pc,
                             input logic [31:0] exp_count, input logic exp_fv,
                             input logic exp_halt);
    compare({name, "_pc"},          pc,          exp_pc);
    compare({name, "_instr_count"}, instr_count, exp_count);
    compare({name, "_fetch_valid"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
    compare({name, "_halted"},      {31'd0, halted},      {31'd0, exp_halt});
  endtask

  // Reset, then the IDLE cycle, landing in RUN at pc=0.
  task automatic resetToRun();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    stepIdle();
  endtask

  initial begin
    int guard;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'd0;
    jump = 1'b0; jump_target = 26'd0; jr_sel = 1'b0; jr_target = 32'd0;

    // Reset values, the IDLE cycle, then RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    checkOutput("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    stepIdle();
    checkOutput("idle", 32'd0, 32'd0, 1'b1, 1'b0);

    // Free run to the end of memory.
    guard = 0;
    while (!halted && guard < 100) begin
      stepIdle();
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      $display("[TB] FAIL freerun_timeout: halted still %0d, expected 1 within 100 cycles", halted);
    end
    checkOutput("freerun_halt", 32'd31, 32'd32, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'd2, 1'b0, 32'd0);
    checkOutput("halt_ignores_jump", 32'd31, 32'd32, 1'b0, 1'b1);

    // Branches backward and forward.
    resetToRun();
    repeat (5) stepIdle();
    checkOutput("at5", 32'd5, 32'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 26'd0, 1'b0, 32'd0);
    checkOutput("branch_back", 32'd3, 32'd6, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 26'd0, 1'b0, 32'd0);
    checkOutput("branch_fwd", 32'd8, 32'd7, 1'b1, 1'b0);

    // Redirect priority.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'd4);
    checkOutput("jr_to4", 32'd4, 32'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 26'd20, 1'b1, 32'd12);
    checkOutput("jr_wins", 32'd12, 32'd9, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 26'd20, 1'b0, 32'd12);
    checkOutput("jump_wins", 32'd20, 32'd10, 1'b1, 1'b0);

    // Stall holds everything and swallows the redirect until released.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'd7);
    checkOutput("jr_to7", 32'd7, 32'd11, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 26'd2, 1'b0, 32'd0);
    checkOutput("stalled", 32'd7, 32'd11, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'd2, 1'b0, 32'd0);
    checkOutput("stall_release", 32'd2, 32'd12, 1'b1, 1'b0);

    // Mid-run reset.
    resetToRun();
    repeat (8) stepIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'd10, 1'b0, 32'd0);
    checkOutput("at10", 32'd10, 32'd9, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    checkOutput("midrun_reset", 32'd0, 32'd0, 1'b0, 1'b0);
    stepIdle();
    checkOutput("after_reset", 32'd0, 32'd0, 1'b1, 1'b0);

    // Out-of-range jr halts; redirects are ignored afterwards.
    repeat (3) stepIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'd40);
    checkOutput("jr_oob_halt", 32'd3, 32'd4, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 26'd6, 1'b1, 32'd5);
    checkOutput("halt_ignores_all", 32'd3, 32'd4, 1'b0, 1'b1);

    // Branch wrapping below zero becomes huge and halts.
    resetToRun();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
    checkOutput("branch_wrap_halt", 32'd0, 32'd1, 1'b0, 1'b1);

    // Stall during IDLE is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    checkOutput("idle_stall_ignored", 32'd0, 32'd0, 1'b1, 1'b0);
    stepIdle();
    checkOutput("first_step", 32'd1, 32'd1, 1'b1, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
